// File: rtl/gpioemu_host.sv
// gpioemu_host: host-side bus sequencer for the multiplier peripheral.
// Ports: clk/reset; job_* in (valid/ready); res_* out (valid/ready);
//        busy; saddress/swr/srd/sdata_out to peripheral, sdata_in from it.
module gpioemu_host #(
  parameter int          SETUP      = 1,
  parameter int          STROBE     = 2,
  parameter int          HOLD       = 1,
  parameter int          POLL_GAP   = 4,
  parameter int          POLL_LIMIT = 1024,
  parameter logic [15:0] ADDR_A1    = 16'h0380,
  parameter logic [15:0] ADDR_A2    = 16'h0388,
  parameter logic [15:0] ADDR_W     = 16'h0390,
  parameter logic [15:0] ADDR_L     = 16'h0398,
  parameter logic [15:0] ADDR_CTRL  = 16'h03A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_ones,
  output logic        res_ovf,
  output logic        res_timeout,
  output logic        busy,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam int T    = SETUP + STROBE + HOLD;
  localparam int CMAX = (T > POLL_GAP) ? T : POLL_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL,
    S_GAP, S_RD_W, S_RD_L, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [23:0]   a1_q, a1_d, a2_q, a2_d;
  logic [1:0]    stat_q, stat_d;
  logic [31:0]   w_q, w_d;
  logic [5:0]    ones_q, ones_d;
  logic          ovf_q, ovf_d, tmo_q, tmo_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   dout_q, dout_d;
  logic          swr_q, swr_d, srd_q, srd_d;
  logic          rv_q, rv_d, jr_q, jr_d, busy_q, busy_d;
  logic          last, smp, stb;

  assign last = (cnt_q == CW'(T - 1));
  assign smp  = (cnt_q == CW'(SETUP + STROBE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    poll_d  = poll_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    stat_d  = stat_q;
    w_d     = w_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (job_valid && jr_q) begin
          state_d = S_WR_A1;
          a1_d    = job_a1;
          a2_d    = job_a2;
          poll_d  = '0;
          w_d     = '0;
          ones_d  = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_WR_A1: if (last) begin
        state_d = S_WR_A2;
        cnt_d   = '0;
      end
      S_WR_A2: if (last) begin
        state_d = S_WR_GO;
        cnt_d   = '0;
      end
      S_WR_GO: if (last) begin
        state_d = S_POLL;
        cnt_d   = '0;
      end
      S_POLL: begin
        if (smp) stat_d = sdata_in[1:0];
        if (last) begin
          cnt_d = '0;
          // bit1 = done; bit0 clear means product overflowed 32 bits
          if (stat_q[1]) begin
            state_d = S_RD_W;
            ovf_d   = !stat_q[0];
          end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
            state_d = S_RESP;
            tmo_d   = 1'b1;
            poll_d  = poll_q + 1'b1;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = (POLL_GAP == 0) ? S_POLL : S_GAP;
          end
        end
      end
      S_GAP: if (int'(cnt_q) >= POLL_GAP - 1) begin
        state_d = S_POLL;
        cnt_d   = '0;
      end
      S_RD_W: begin
        if (smp) w_d = sdata_in;
        if (last) begin
          state_d = S_RD_L;
          cnt_d   = '0;
        end
      end
      S_RD_L: begin
        if (smp) ones_d = sdata_in[5:0];
        if (last) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        cnt_d = '0;
        if (rv_q && res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Bus outputs are registered from the next state and phase
    stb    = (int'(cnt_d) >= SETUP) && (int'(cnt_d) < SETUP + STROBE);
    addr_d = '0;
    dout_d = '0;
    swr_d  = 1'b0;
    srd_d  = 1'b0;
    unique case (state_d)
      S_WR_A1: begin
        addr_d = ADDR_A1;
        dout_d = {8'h0, a1_d};
        swr_d  = stb;
      end
      S_WR_A2: begin
        addr_d = ADDR_A2;
        dout_d = {8'h0, a2_d};
        swr_d  = stb;
      end
      S_WR_GO: begin
        addr_d = ADDR_CTRL;
        dout_d = 32'h1;
        swr_d  = stb;
      end
      S_POLL: begin
        addr_d = ADDR_CTRL;
        srd_d  = stb;
      end
      S_RD_W: begin
        addr_d = ADDR_W;
        srd_d  = stb;
      end
      S_RD_L: begin
        addr_d = ADDR_L;
        srd_d  = stb;
      end
      default: ;
    endcase
    rv_d   = (state_d == S_RESP);
    jr_d   = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      stat_q  <= '0;
      w_q     <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      swr_q   <= 1'b0;
      srd_q   <= 1'b0;
      rv_q    <= 1'b0;
      jr_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      stat_q  <= stat_d;
      w_q     <= w_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      swr_q   <= swr_d;
      srd_q   <= srd_d;
      rv_q    <= rv_d;
      jr_q    <= jr_d;
      busy_q  <= busy_d;
    end
  end

  assign job_ready   = jr_q;
  assign res_valid   = rv_q;
  assign res_w       = w_q;
  assign res_ones    = ones_q;
  assign res_ovf     = ovf_q;
  assign res_timeout = tmo_q;
  assign busy        = busy_q;
  assign saddress    = addr_q;
  assign swr         = swr_q;
  assign srd         = srd_q;
  assign sdata_out   = dout_q;

endmodule

// File: tb/tb_gpioemu_host.sv
// tb_gpioemu_host: scoreboard bench for gpioemu_host.
// Peripheral responder, bus/result monitor, directed job vectors.
module tb_gpioemu_host;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  ones;
    logic        ovf;
    logic        tmo;
    int          lat;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [23:0] job_a1 = '0;
  logic [23:0] job_a2 = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_w;
  logic [5:0]  res_ones;
  logic        res_ovf, res_timeout, busy;
  logic [15:0] saddress;
  logic        swr, srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  gpioemu_host #(.POLL_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a1(job_a1), .job_a2(job_a2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_w(res_w), .res_ones(res_ones),
    .res_ovf(res_ovf), .res_timeout(res_timeout),
    .busy(busy), .saddress(saddress),
    .swr(swr), .srd(srd),
    .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;
  int polls = 0;
  int rv_cnt = 0;
  int overlap = 0;
  int bus_err = 0;
  int nb = 0;
  logic [1:0]  bs = 2'b01, ds = 2'b11;
  logic [31:0] wv = '0, lv = '0;
  logic        rst_e = 1'b1;

  logic [48:0] exp_bus[$];
  res_t        exp_res[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= reset;
  end

  // Peripheral model: status busy for the first nb polls of a job
  always_comb begin
    sdata_in = 32'h0;
    if (saddress == 16'h03A0)
      sdata_in = {30'h0, (polls <= nb) ? bs : ds};
    else if (saddress == 16'h0390)
      sdata_in = wv;
    else if (saddress == 16'h0398)
      sdata_in = lv;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  logic        swr_p = 1'b0, srd_p = 1'b0, rv_p = 1'b0;
  logic [15:0] addr_p = '0, lat_addr = '0;

  always @(negedge clk) begin
    logic [48:0] ev;
    res_t r;
    if (swr && srd) overlap++;
    if ((swr && !swr_p) || (srd && !srd_p)) begin
      ev = {swr, saddress, swr ? sdata_out : 32'h0};
      if (saddress !== addr_p) bus_err++;
      lat_addr = saddress;
      if (swr && saddress == 16'h0380) polls = 0;
      if (srd && saddress == 16'h03A0) polls++;
      if (exp_bus.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL bus_extra: got %h required none", ev);
      end else begin
        chk("bus_access", 64'(ev), 64'(exp_bus.pop_front()));
      end
    end else if ((swr || srd) && saddress !== lat_addr) begin
      bus_err++;
    end else if ((swr_p || srd_p) && !rst_e && saddress !== lat_addr) begin
      bus_err++;
    end
    if (res_valid && !rv_p) begin
      rv_cnt++;
      if (exp_res.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL res_extra: got w=%h required none", res_w);
      end else begin
        r = exp_res.pop_front();
        chk("res_w", 64'(res_w), 64'(r.w));
        chk("res_ones", 64'(res_ones), 64'(r.ones));
        chk("res_ovf", 64'(res_ovf), 64'(r.ovf));
        chk("res_timeout", 64'(res_timeout), 64'(r.tmo));
        chk("res_latency", 64'(cyc - base), 64'(r.lat));
      end
    end
    swr_p  = swr;
    srd_p  = srd;
    addr_p = saddress;
    rv_p   = res_valid;
  end

  task automatic launch(input logic [23:0] a1,
                        input logic [23:0] a2,
                        input bit pulse);
    int k = 0;
    @(negedge clk);
    while (!job_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    job_a1    = a1;
    job_a2    = a2;
    job_valid = 1'b1;
    base      = cyc;
    @(negedge clk);
    job_valid = 1'b0;
    job_a1    = 24'h5A5A5A;
    job_a2    = 24'hA5A5A5;
    if (pulse) begin
      repeat (3) @(negedge clk);
      job_valid = 1'b1;
      repeat (2) @(negedge clk);
      job_valid = 1'b0;
    end
  endtask

  task automatic run_job(input logic [23:0] a1, input logic [23:0] a2,
                         input int nbz, input logic [1:0] bst,
                         input logic [1:0] dst,
                         input logic [31:0] wvi, input logic [31:0] lvi,
                         input logic [31:0] ew, input logic [5:0] eo,
                         input logic eovf, input logic etmo,
                         input int npoll, input int elat, input int rdly);
    res_t r;
    int k;
    logic [31:0] sw;
    logic [5:0]  so;
    logic        stab;
    nb = nbz;
    bs = bst;
    ds = dst;
    wv = wvi;
    lv = lvi;
    exp_bus.push_back({1'b1, 16'h0380, 8'h0, a1});
    exp_bus.push_back({1'b1, 16'h0388, 8'h0, a2});
    exp_bus.push_back({1'b1, 16'h03A0, 32'h1});
    for (int i = 0; i < npoll; i++)
      exp_bus.push_back({1'b0, 16'h03A0, 32'h0});
    if (!etmo) begin
      exp_bus.push_back({1'b0, 16'h0390, 32'h0});
      exp_bus.push_back({1'b0, 16'h0398, 32'h0});
    end
    r = '{ew, eo, eovf, etmo, elat};
    exp_res.push_back(r);
    res_ready = (rdly == 0);
    launch(a1, a2, 1'b1);
    if (rdly > 0) begin
      k = 0;
      while (!res_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      sw   = res_w;
      so   = res_ones;
      stab = 1'b0;
      repeat (rdly) begin
        @(negedge clk);
        if (!res_valid || job_ready || swr || srd ||
            res_w !== sw || res_ones !== so) stab = 1'b1;
      end
      chk("hold_stable", 64'(stab), 64'(0));
      res_ready = 1'b1;
      @(negedge clk);
      chk("ready_after_hs", 64'(job_ready), 64'(1));
      chk("valid_after_hs", 64'(res_valid), 64'(0));
    end
    k = 0;
    while ((exp_res.size() != 0 || !job_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("job_done", 64'(exp_res.size()), 64'(0));
    chk("bus_left", 64'(exp_bus.size()), 64'(0));
    exp_res.delete();
    exp_bus.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int rv0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_bus", 64'({saddress, swr, srd}), 64'(0));
    chk("rst_sdata_out", 64'(sdata_out), 64'(0));
    chk("rst_res", 64'({res_w, res_ones, res_ovf, res_timeout}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_job(24'd3, 24'd5, 0, 2'b01, 2'b11, 32'd15, 32'd4,
            32'd15, 6'd4, 1'b0, 1'b0, 1, 25, 0);
    run_job(24'hFFFFFF, 24'hFFFFFF, 0, 2'b01, 2'b10,
            32'hFE000001, 32'hABCD0048,
            32'hFE000001, 6'd8, 1'b1, 1'b0, 1, 25, 0);
    run_job(24'd7, 24'd9, 3, 2'b01, 2'b11, 32'd63, 32'd6,
            32'd63, 6'd6, 1'b0, 1'b0, 4, 49, 0);
    run_job(24'd1, 24'd2, 100, 2'b01, 2'b11, 32'hDEAD, 32'h3F,
            32'd0, 6'd0, 1'b0, 1'b1, 8, 73, 0);
    run_job(24'd10, 24'd20, 0, 2'b01, 2'b11, 32'd200, 32'd3,
            32'd200, 6'd3, 1'b0, 1'b0, 1, 25, 10);

    // Reset while the A2 write strobe is high
    rv0 = rv_cnt;
    exp_bus.push_back({1'b1, 16'h0380, 32'h11});
    exp_bus.push_back({1'b1, 16'h0388, 32'h22});
    launch(24'h11, 24'h22, 1'b0);
    k = 0;
    while (!(swr && saddress == 16'h0388) && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("a2_strobe_seen", 64'({swr, saddress}), 64'({1'b1, 16'h0388}));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_swr", 64'(swr), 64'(0));
    chk("mid_rst_addr", 64'(saddress), 64'(0));
    chk("mid_rst_ready", 64'(job_ready), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_res_after_rst", 64'(rv_cnt - rv0), 64'(0));
    chk("rst_bus_left", 64'(exp_bus.size()), 64'(0));
    chk("strobe_overlap", 64'(overlap), 64'(0));
    chk("addr_stability", 64'(bus_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpioemu_host.md
# gpioemu_host

Bus-initiator sequencer that drives the multiplier peripheral's register interface (saddress/srd/swr/data) from the host side. It accepts a 24×24 multiply job on a valid/ready port and writes both operands. It then writes the start register, polls status until the peripheral reports completion, and reads back product and ones-count. It returns them on a valid/ready result port. It sits between a client engine (testbench or CPU-side logic) and the peripheral's edge-strobed bus.

## Interface
- SETUP, default 1: cycles address/data are stable before a strobe rises (≥1).
- STROBE, default 2: cycles srd/swr are held high (≥1).
- HOLD, default 1: cycles address/data are held after a strobe falls (≥1).
- POLL_GAP, default 4: idle cycles between consecutive status polls.
- POLL_LIMIT, default 1024: maximum status polls per job before timeout (≥1).
- ADDR_A1, ADDR_A2, ADDR_W, ADDR_L, ADDR_CTRL, defaults 16'h0380, 16'h0388, 16'h0390, 16'h0398, 16'h03A0.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_a1  in  24  operand 1.
- job_a2  in  24  operand 2.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  result consumer ready.
- res_w  out  32  product low word (read from ADDR_W).
- res_ones  out  6  ones count (ADDR_L read, bits [5:0]).
- res_ovf  out  1  high when final status bit0 = 0 (product exceeds 32 bits).
- res_timeout  out  1  poll limit hit; res_w/res_ones/res_ovf = 0.
- busy  out  1  high in every state except IDLE.
- saddress  out  16  peripheral register address.
- swr  out  1  write strobe (peripheral acts on its rising edge).
- srd  out  1  read strobe (peripheral acts on its rising edge).
- sdata_out  out  32  write data to peripheral.
- sdata_in  in  32  read data from peripheral.

## Operation
- All outputs registered. Reset values: saddress=0, swr=0, srd=0, sdata_out=0, job_ready=1, busy=0, res_valid=0, res_w=0, res_ones=0, res_ovf=0, res_timeout=0. Poll counter and phase counter are cleared.
- States: IDLE → WR_A1 → WR_A2 → WR_GO → POLL → (GAP → POLL)* → RD_W → RD_L → RESP → IDLE. TIMEOUT path: POLL → RESP.
- IDLE: on job_valid&&job_ready, capture a1/a2 and go to WR_A1.
- Every access is a SETUP phase (address/data driven, strobe low), then a STROBE phase (strobe high), then a HOLD phase (strobe low, address/data unchanged). Each access lasts SETUP+STROBE+HOLD cycles. Exactly one rising strobe edge occurs per access, and never swr and srd together.
- WR_A1 writes {8'h0,a1} to ADDR_A1. WR_A2 writes {8'h0,a2} to ADDR_A2. WR_GO writes 32'h1 to ADDR_CTRL.
- POLL reads ADDR_CTRL. sdata_in is sampled on the clock edge ending the last STROBE cycle.
  - If the sampled value [1:0]==2'b11, go to RD_W.
  - If it is 2'b10, go to RD_W and set ovf. Bit1 alone signals done; bit0 is the valid flag.
  - Otherwise increment the poll count. If the count equals POLL_LIMIT, go to RESP with res_timeout=1; else go to GAP for POLL_GAP cycles, all bus outputs idle.
  - Completion condition is status bit1 = 1. res_ovf = !bit0.
- RD_W captures sdata_in → res_w. RD_L captures sdata_in[5:0] → res_ones. Sampling point is the same as for POLL.
- RESP: res_valid=1 with outputs stable until the res_valid&&res_ready edge. Then go to IDLE; job_ready returns high the next cycle. No job is accepted in the same cycle as the result handshake.
- Idle bus: saddress=0, sdata_out=0, strobes low (IDLE, GAP, RESP).

## Timing
- Access length T = SETUP+STROBE+HOLD (default 4).
- With defaults, accept edge at cycle 0. WR_A1 occupies cycles 1–4, WR_A2 5–8, WR_GO 9–12, first POLL 13–16.
- If the first poll completes: RD_W 17–20, RD_L 21–24, res_valid high from cycle 25.
- Each extra poll adds POLL_GAP+T cycles (default 8).
- swr rises in cycle SETUP+1 of its access. The peripheral sees saddress/sdata stable ≥SETUP cycles before and ≥HOLD cycles after the edge.
- Reset mid-operation, including with a strobe high: on the next cycle all outputs are at reset values and the state is IDLE. No partial result is emitted.
- job_valid while not IDLE is ignored. Operands are not resampled after acceptance.
- res_ready high before res_valid: the handshake completes in the first RESP cycle.

## Test plan
- a1=3, a2=5, responder returns status 2'b11 on first poll, W=15, L=4 → bus sequence 0380←3, 0388←5, 03A0←1, read 03A0, 0390, 0398; res_w=15, res_ones=4, res_ovf=0, res_valid at cycle 25.
- a1=24'hFFFFFF, a2=24'hFFFFFF, status 2'b10, W=32'hFE000001, L=8 → res_w=32'hFE000001, res_ones=8, res_ovf=1.
- Status 2'b01 for 3 polls then 2'b11 → 4 status reads, each separated by exactly 4 idle cycles; res_valid at cycle 49.
- POLL_LIMIT=8, status stuck at 2'b01 → exactly 8 status reads, no reads of 0390/0398; res_timeout=1, res_w=0, res_ones=0.
- res_ready held low 10 cycles after res_valid → outputs stable, job_ready=0, no bus strobes; job_ready=1 the cycle after handshake.
- reset asserted during WR_A2 while swr=1 → next cycle swr=0, saddress=0, job_ready=1, busy=0; no res_valid afterward.
